ansi_decoder: RTL and testbench
===============================

// Module: ansi_decoder
// PURPOSE
//  Byte-stream filter between the UART receiver and the text controller.
//  - Ordinary bytes pass through unchanged.
//  - A small subset of ANSI/VT100 CSI escape sequences is translated into the controller's native codes:
//    - CUP moves the cursor and becomes DC4 + row + col.
//    - ED2 clears the screen and becomes FF.
//  - Every other escape sequence is swallowed.
//  - Valid/ready handshake on both sides.
// PARAMETERS
//  LAST_ROW  16  highest row index the controller accepts; CUP row is clamped to it
//  LAST_COL  59  highest column index the controller accepts; CUP col is clamped to it
// PORTS
//  i_clk      in   1  system clock, 12 MHz
//  i_rst      in   1  synchronous reset, active-high
//  i_char     in   8  byte from UART receiver
//  i_valid    in   1  i_char valid
//  o_ready    out  1  decoder accepts i_char this cycle
//  o_char     out  8  byte to text controller
//  o_valid    out  1  o_char valid
//  i_ready    in   1  controller accepts o_char this cycle
// BEHAVIOUR
//  Interface and handshake
//  - One clock (i_clk). Reset is synchronous, active-high (i_rst).
//  - Reset values: o_valid=0, o_char=8'h00, state=GROUND, p0=p1=0, pidx=0. o_ready=1 in the first cycle after reset.
//  - Input transfer = i_valid & o_ready. Output transfer = o_valid & i_ready.
//  - o_ready = (state != EMIT) & (!o_valid | i_ready). This is combinational and does not depend on i_valid.
//  - o_char is held stable while o_valid & !i_ready. o_valid drops only after a transfer.
//  - Pass-through latency: o_valid rises 1 cycle after the input transfer. Sustained throughput is 1 byte/cycle.
//  State machine
//  - GROUND, byte accepted:
//    - 8'h1B (ESC): go to ESC; nothing is emitted.
//    - any other byte: load it into o_char and set o_valid.
//  - ESC, byte accepted:
//    - '[' : clear p0, p1, pidx; go to CSI.
//    - ESC: stay in ESC.
//    - anything else: drop the byte; go to GROUND.
//  - CSI, byte accepted:
//    - '0'-'9': p[pidx] = p[pidx]*10 + digit, computed 12 bits wide and saturated at 255.
//    - ';': pidx = pidx+1. A third or later parameter is parsed into a discard slot, so p0 and p1 are unchanged.
//    - 'H' or 'f': queue DC4, R, C; go to EMIT.
//    - 'J' with p0==2: queue FF; go to EMIT.
//    - 'J' with any other p0: discard; go to GROUND.
//    - ESC: restart at ESC.
//    - 8'h18 (CAN) or 8'h1A (SUB): abort; go to GROUND; nothing is emitted.
//    - any other byte in 8'h40-8'h7E: final byte of an unsupported sequence; discard; go to GROUND.
//    - any other byte: ignored; stay in CSI.
//  - EMIT:
//    - Queued bytes are presented in order. The next byte loads in the same cycle as the previous one's output transfer.
//    - Go to GROUND when the last byte transfers.
//    - o_ready=0 throughout EMIT.
//    - The first queued byte loads on the cycle the final byte is accepted, so it appears 1 cycle later. There are no bubbles.
//  CUP arithmetic
//  - Parameters are 1-based; a value of 0 or an omitted parameter means 1.
//  - R = min(max(p0,1)-1, LAST_ROW) + 8'h20.
//  - C = min(max(p1,1)-1, LAST_COL) + 8'h20.
//  - The 8'h20 offset matches the controller's DC4 argument encoding.
//  Boundaries
//  - Digit overflow saturates at 255, which then clamps to LAST_ROW / LAST_COL. It never wraps.
//  - An input transfer and an output transfer in the same cycle are legal.
//  - Reset mid-sequence or mid-EMIT: the cycle after i_rst, o_valid=0 and state=GROUND. The partial sequence is lost.
// TESTING
//  1. i_ready=1; send 'A' (8'h41). Required: o_valid=1 with o_char=8'h41 on the next cycle, o_ready stays 1.
//  2. Send ESC [ 5 ; 1 0 H. Required: exactly 3 outputs, 8'h14, 8'h24, 8'h29, and o_ready=0 until the last one transfers.
//  3. Send ESC [ H, then ESC [ 99 ; 300 H. Required: 8'h14,8'h20,8'h20, then 8'h14,8'h30,8'h5B (clamped, no wrap).
//  4. Send ESC [ 2 J, then ESC [ 1 J, then ESC [ 3 1 m, then ESC x, then 'B'. Required: outputs are exactly 8'h0C, 8'h42.
//  5. Hold i_ready=0 during ESC [ 2 ; 3 H. Required: o_char=8'h14 stable, o_valid=1, o_ready=0. Release i_ready: 8'h21, 8'h22 follow back-to-back.
//  6. Send ESC [ 4 CAN 'C'. Required: only 8'h43 is output. Assert i_rst mid-EMIT: required o_valid=0 next cycle, and a fresh 'D' passes through.

Source files
------------

// File: rtl/ansi_decoder.sv
// ANSI/VT100 CSI filter between UART receiver and text controller.
// Translates CUP to DC4+row+col and ED2 to FF; swallows other escapes.
module ansi_decoder #(
  parameter int unsigned LAST_ROW = 16,
  parameter int unsigned LAST_COL = 59
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_char,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_char,
  output logic       o_valid,
  input  logic       i_ready
);

  typedef enum logic [1:0] {
    GROUND,
    ESC,
    CSI,
    EMIT
  } state_t;

  localparam logic [7:0] C_ESC = 8'h1B;
  localparam logic [7:0] C_DC4 = 8'h14;
  localparam logic [7:0] C_FF  = 8'h0C;
  localparam logic [7:0] C_CAN = 8'h18;
  localparam logic [7:0] C_SUB = 8'h1A;

  state_t     state_q, state_d;
  logic [7:0] p0_q, p0_d;
  logic [7:0] p1_q, p1_d;
  logic [1:0] pidx_q, pidx_d;
  logic [7:0] char_q, char_d;
  logic       valid_q, valid_d;
  logic [7:0] q1_q, q1_d;
  logic [7:0] q2_q, q2_d;
  logic [1:0] qcnt_q, qcnt_d;

  logic        in_xfer;
  logic        out_xfer;
  logic [7:0]  pcur;
  logic [11:0] acc;
  logic [7:0]  pnext;
  logic        is_digit;
  logic        is_final;

  function automatic logic [7:0] coord(
    input logic [7:0] p,
    input logic [7:0] lim
  );
    logic [7:0] m;
    m = (p == 8'd0) ? 8'd0 : p - 8'd1;
    if (m > lim) m = lim;
    return m + 8'h20;
  endfunction

  assign o_ready  = (state_q != EMIT) & (!valid_q | i_ready);
  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = valid_q & i_ready;
  assign o_char   = char_q;
  assign o_valid  = valid_q;

  assign is_digit = (i_char >= 8'h30) && (i_char <= 8'h39);
  assign is_final = (i_char >= 8'h40) && (i_char <= 8'h7E);

  // 12-bit accumulate so 255*10+9 cannot wrap before saturation
  assign pcur  = (pidx_q == 2'd0) ? p0_q : p1_q;
  assign acc   = {4'd0, pcur} * 12'd10 + {8'd0, i_char[3:0]};
  assign pnext = (acc > 12'd255) ? 8'd255 : acc[7:0];

  always_comb begin
    state_d = state_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    pidx_d  = pidx_q;
    char_d  = char_q;
    valid_d = valid_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    qcnt_d  = qcnt_q;
    if (out_xfer) valid_d = 1'b0;
    unique case (state_q)
      GROUND: begin
        if (in_xfer) begin
          if (i_char == C_ESC) begin
            state_d = ESC;
          end else begin
            char_d  = i_char;
            valid_d = 1'b1;
          end
        end
      end
      ESC: begin
        if (in_xfer) begin
          if (i_char == 8'h5B) begin
            p0_d    = 8'd0;
            p1_d    = 8'd0;
            pidx_d  = 2'd0;
            state_d = CSI;
          end else if (i_char != C_ESC) begin
            state_d = GROUND;
          end
        end
      end
      CSI: begin
        if (in_xfer) begin
          if (is_digit) begin
            if (pidx_q == 2'd0) p0_d = pnext;
            else if (pidx_q == 2'd1) p1_d = pnext;
          end else if (i_char == 8'h3B) begin
            if (pidx_q != 2'd2) pidx_d = pidx_q + 2'd1;
          end else if (i_char == 8'h48 || i_char == 8'h66) begin
            char_d  = C_DC4;
            valid_d = 1'b1;
            q1_d    = coord(p0_q, 8'(LAST_ROW));
            q2_d    = coord(p1_q, 8'(LAST_COL));
            qcnt_d  = 2'd2;
            state_d = EMIT;
          end else if (i_char == 8'h4A) begin
            if (p0_q == 8'd2) begin
              char_d  = C_FF;
              valid_d = 1'b1;
              qcnt_d  = 2'd0;
              state_d = EMIT;
            end else begin
              state_d = GROUND;
            end
          end else if (i_char == C_ESC) begin
            state_d = ESC;
          end else if (i_char == C_CAN || i_char == C_SUB) begin
            state_d = GROUND;
          end else if (is_final) begin
            state_d = GROUND;
          end
        end
      end
      EMIT: begin
        if (out_xfer) begin
          if (qcnt_q == 2'd0) begin
            state_d = GROUND;
          end else begin
            char_d  = q1_q;
            q1_d    = q2_q;
            valid_d = 1'b1;
            qcnt_d  = qcnt_q - 2'd1;
          end
        end
      end
      default: state_d = GROUND;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= GROUND;
      p0_q    <= 8'd0;
      p1_q    <= 8'd0;
      pidx_q  <= 2'd0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      q1_q    <= 8'd0;
      q2_q    <= 8'd0;
      qcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      pidx_q  <= pidx_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      qcnt_q  <= qcnt_d;
    end
  end

endmodule

// File: tb/tb_ansi_decoder.sv
// Directed table-driven bench for ansi_decoder.
// Inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_ansi_decoder;

  logic       clk;
  logic       i_rst;
  logic [7:0] i_char;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_char;
  logic       o_valid;
  logic       i_ready;

  ansi_decoder #(
    .LAST_ROW(16),
    .LAST_COL(59)
  ) dut (
    .i_clk  (clk),
    .i_rst  (i_rst),
    .i_char (i_char),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_char (o_char),
    .o_valid(o_valid),
    .i_ready(i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    string       si;
    int          no;
    logic [31:0] ob;
  } vec_t;

  vec_t       vq[$];
  logic [7:0] outq[$];
  int         n_chk;
  int         n_fail;
  int         wait_acc;

  always @(negedge clk) begin
    if (!i_rst && o_valid && i_ready) outq.push_back(o_char);
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    @(posedge clk);
    #1;
    i_char  = b;
    i_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!o_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    wait_acc += n;
    if (!o_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: o_ready stuck at 0 for byte %0h", b);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic add(input string nm, input string si, input int no,
                     input logic [31:0] ob);
    vec_t v;
    v.nm = nm;
    v.si = si;
    v.no = no;
    v.ob = ob;
    vq.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    wait_acc = 0;
    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_char   = 8'h00;
    i_ready  = 1'b1;

    add("pass_A",     "A",                    1, 32'h41);
    add("cup_5_10",   "\033[5;10H",           3, {8'h14, 8'h24, 8'h29});
    add("cup_home",   "\033[H",               3, {8'h14, 8'h20, 8'h20});
    add("cup_clamp",  "\033[99;300H",         3, {8'h14, 8'h30, 8'h5B});
    add("ed2",        "\033[2J",              1, 32'h0C);
    add("ed1_drop",   "\033[1J",              0, 32'h0);
    add("sgr_drop",   "\033[31m",             0, 32'h0);
    add("esc_x_drop", "\033x",                0, 32'h0);
    add("pass_B",     "B",                    1, 32'h42);
    add("can_abort",  "\033[4\030C",          1, 32'h43);
    add("sub_abort",  "\033[5\032x",          1, 32'h78);
    add("cup_f_3rd",  "\033[3;7;9f",          3, {8'h14, 8'h22, 8'h26});
    add("esc_esc",    "\033\033[2J",          1, 32'h0C);
    add("cup_zero",   "\033[0;0H",            3, {8'h14, 8'h20, 8'h20});
    add("cup_edge",   "\033[17;60H",          3, {8'h14, 8'h30, 8'h5B});
    add("cup_sat",    "\033[256;1H",          3, {8'h14, 8'h30, 8'h20});
    add("csi_ignore", "\033[ 3H",             3, {8'h14, 8'h22, 8'h20});
    add("csi_restart","\033[2\033[J",         0, 32'h0);
    add("pass_PQR",   "PQR",                  3, {8'h50, 8'h51, 8'h52});

    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_char",  o_char,  8'h00);
    chk("rst_o_ready", o_ready, 1'b1);

    // pass-through latency
    outq.delete();
    @(posedge clk);
    #1;
    i_char  = 8'h41;
    i_valid = 1'b1;
    @(negedge clk);
    chk("lat_ready_pre", o_ready, 1'b1);
    chk("lat_valid_pre", o_valid, 1'b0);
    idle();
    @(negedge clk);
    chk("lat_valid", o_valid, 1'b1);
    chk("lat_char",  o_char,  8'h41);
    chk("lat_ready", o_ready, 1'b1);
    repeat (4) @(negedge clk);

    foreach (vq[i]) begin
      outq.delete();
      send_str(vq[i].si);
      idle();
      repeat (8) @(negedge clk);
      chk({vq[i].nm, "_count"}, outq.size(), vq[i].no);
      for (int k = 0; k < vq[i].no && k < outq.size(); k++)
        chk({vq[i].nm, "_byte"}, outq[k],
            vq[i].ob[8*(vq[i].no-1-k) +: 8]);
    end

    // no stalls on back-to-back pass-through
    wait_acc = 0;
    send_str("XYZ");
    idle();
    chk("throughput_stalls", wait_acc, 0);
    repeat (4) @(negedge clk);

    // o_ready low throughout EMIT
    send_str("\033[5;10H");
    idle();
    @(negedge clk);
    chk("emit0_char",  o_char,  8'h14);
    chk("emit0_ready", o_ready, 1'b0);
    @(negedge clk);
    chk("emit1_char",  o_char,  8'h24);
    chk("emit1_ready", o_ready, 1'b0);
    @(negedge clk);
    chk("emit2_char",  o_char,  8'h29);
    chk("emit2_ready", o_ready, 1'b0);
    @(negedge clk);
    chk("emit_done_valid", o_valid, 1'b0);
    chk("emit_done_ready", o_ready, 1'b1);

    // backpressure hold then back-to-back release
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    send_str("\033[2;3H");
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", o_valid, 1'b1);
      chk("stall_char",  o_char,  8'h14);
      chk("stall_ready", o_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    @(negedge clk);
    chk("rel0_char", o_char, 8'h14);
    @(negedge clk);
    chk("rel1_char", o_char, 8'h21);
    chk("rel1_valid", o_valid, 1'b1);
    @(negedge clk);
    chk("rel2_char", o_char, 8'h22);
    chk("rel2_valid", o_valid, 1'b1);
    @(negedge clk);
    chk("rel_done_valid", o_valid, 1'b0);

    // reset mid-sequence drops the partial CSI
    outq.delete();
    send_str("\033[1");
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_rst   = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    send_str("2J");
    idle();
    repeat (6) @(negedge clk);
    chk("rst_seq_count", outq.size(), 2);
    if (outq.size() == 2) begin
      chk("rst_seq_b0", outq[0], 8'h32);
      chk("rst_seq_b1", outq[1], 8'h4A);
    end

    // reset mid-EMIT
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    send_str("\033[2;3H");
    idle();
    @(negedge clk);
    chk("pre_rst_valid", o_valid, 1'b1);
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_emit_valid", o_valid, 1'b0);
    chk("rst_emit_ready", o_ready, 1'b1);
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    outq.delete();
    send(8'h44);
    idle();
    repeat (6) @(negedge clk);
    chk("fresh_D_count", outq.size(), 1);
    if (outq.size() == 1) chk("fresh_D_byte", outq[0], 8'h44);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
